// File: rtl/auto_range_ctrl_pkg.sv
// Shared definitions for the auto-ranging gain controller.
//   ar_state_e      : controller state encoding (TRACK / SETTLE)
//   AR_* constants  : default parameter values used by the interface and top
package auto_range_pkg;

  typedef enum logic [0:0] {
    TRACK  = 1'b0,
    SETTLE = 1'b1
  } ar_state_e;

  localparam int AR_NCH          = 4;
  localparam int AR_DW           = 12;
  localparam int AR_DEPTH        = 5;
  localparam int AR_NRANGE       = 21;
  localparam int AR_GROUP        = 10;
  localparam int AR_SHORT_SETTLE = 16;
  localparam int AR_LONG_SETTLE  = 10000;

endpackage

// File: rtl/auto_range_ctrl_if.sv
// Sample/control bundle of the auto-ranging controller.
//   ch_data      : NCH packed unsigned samples, channel k at [k*DW +: DW]
//   sample_valid : one-cycle strobe for a new ch_data set
//   hi_thr       : saturation threshold (inclusive)
//   lo_thr       : under-range threshold (inclusive)
//   hold         : blocks starting a range change
//   range_idx    : current gain range (0 = highest gain)
//   range_step   : one-cycle pulse on each range change
//   settling     : high while relays settle
//   sat_flag     : saturated at the lowest-gain range
// master drives the samples/thresholds, slave is the controller.
interface auto_range_ctrl_if
  import auto_range_pkg::*;
#(
  parameter int NCH    = AR_NCH,
  parameter int DW     = AR_DW,
  parameter int NRANGE = AR_NRANGE
);
  localparam int RW = $clog2(NRANGE);

  logic [NCH*DW-1:0] ch_data;
  logic              sample_valid;
  logic [DW-1:0]     hi_thr;
  logic [DW-1:0]     lo_thr;
  logic              hold;
  logic [RW-1:0]     range_idx;
  logic              range_step;
  logic              settling;
  logic              sat_flag;

  modport master (
    output ch_data, sample_valid, hi_thr, lo_thr, hold,
    input  range_idx, range_step, settling, sat_flag
  );

  modport slave (
    input  ch_data, sample_valid, hi_thr, lo_thr, hold,
    output range_idx, range_step, settling, sat_flag
  );

endinterface

// File: rtl/auto_range_ctrl_history.sv
// Peak history window for the auto-ranging controller.
//   clk, rst_n   : clock, asynchronous active-low reset
//   shift_en     : push peak into entry 0 (older entries move toward DEPTH-1)
//   clear        : restart the fill count (takes priority over shift_en)
//   peak         : current per-sample peak
//   hi_thr/lo_thr: thresholds for the all-entries comparisons
//   full         : DEPTH samples collected since the last clear
//   hi_all       : every entry >= hi_thr
//   lo_all       : every entry <= lo_thr
module ar_history
  import auto_range_pkg::*;
#(
  parameter int NCH   = AR_NCH,
  parameter int DW    = AR_DW,
  parameter int DEPTH = AR_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          shift_en,
  input  logic          clear,
  input  logic [DW-1:0] peak,
  input  logic [DW-1:0] hi_thr,
  input  logic [DW-1:0] lo_thr,
  output logic          full,
  output logic          hi_all,
  output logic          lo_all
);
  localparam int FW = $clog2(DEPTH + 1);

  if (NCH < 1 || DEPTH < 1) begin : g_bad_param
    $error("ar_history: NCH and DEPTH must be at least 1");
  end

  logic [DW-1:0] hist [DEPTH];
  logic [FW-1:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      if (shift_en) begin
        hist[0] <= peak;
        for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
      end
      // Stale entries are left in place after a clear; they are only
      // trusted again once DEPTH fresh samples have overwritten them.
      if (clear) fill <= '0;
      else if (shift_en && fill != FW'(DEPTH)) fill <= fill + 1'b1;
    end
  end

  always_comb begin
    hi_all = 1'b1;
    lo_all = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (hist[i] < hi_thr) hi_all = 1'b0;
      if (hist[i] > lo_thr) lo_all = 1'b0;
    end
  end

  assign full = (fill == FW'(DEPTH));

endmodule

// File: rtl/auto_range_ctrl.sv
// Auto-ranging gain controller: tracks the peak of NCH ADC channels over a
// DEPTH-sample window, steps the gain range up on sustained saturation or down
// on sustained under-range, then waits for the relays to settle.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : auto_range_ctrl_if.slave (samples, thresholds, hold, range outputs)
module auto_range_ctrl
  import auto_range_pkg::*;
#(
  parameter int NCH          = AR_NCH,
  parameter int DW           = AR_DW,
  parameter int DEPTH        = AR_DEPTH,
  parameter int NRANGE       = AR_NRANGE,
  parameter int GROUP        = AR_GROUP,
  parameter int SHORT_SETTLE = AR_SHORT_SETTLE,
  parameter int LONG_SETTLE  = AR_LONG_SETTLE
) (
  input  logic             clk,
  input  logic             rst_n,
  auto_range_ctrl_if.slave bus
);
  localparam int RW = $clog2(NRANGE);
  localparam int CW = $clog2(LONG_SETTLE + 1);
  localparam logic [RW-1:0] RANGE_MAX = RW'(NRANGE - 1);
  localparam logic [0:0]    ST_TRACK  = TRACK;
  localparam logic [0:0]    ST_SETTLE = SETTLE;

  logic [DW-1:0] peak;
  logic          full, hi_all, lo_all;
  logic [0:0]    state;
  logic [RW-1:0] range_idx, next_idx;
  logic          range_step;
  logic [CW-1:0] settle_cnt;
  logic          in_track, go_up, go_dn, change, cross_group;

  always_comb begin
    peak = bus.ch_data[0 +: DW];
    for (int k = 1; k < NCH; k++)
      if (bus.ch_data[k*DW +: DW] > peak) peak = bus.ch_data[k*DW +: DW];
  end

  ar_history #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (bus.sample_valid && in_track),
    .clear    (change),
    .peak     (peak),
    .hi_thr   (bus.hi_thr),
    .lo_thr   (bus.lo_thr),
    .full     (full),
    .hi_all   (hi_all),
    .lo_all   (lo_all)
  );

  assign in_track = (state == ST_TRACK);
  // hi_all wins when both hold (misconfigured thresholds), even at the top limit.
  assign go_up  = in_track && full && !bus.hold && hi_all && (range_idx != RANGE_MAX);
  assign go_dn  = in_track && full && !bus.hold && !hi_all && lo_all && (range_idx != '0);
  assign change = go_up || go_dn;
  assign next_idx    = go_up ? range_idx + 1'b1 : range_idx - 1'b1;
  // Crossing into another relay group needs the long mechanical settle.
  assign cross_group = (int'(range_idx) / GROUP) != (int'(next_idx) / GROUP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_TRACK;
      range_idx  <= '0;
      range_step <= 1'b0;
      settle_cnt <= '0;
    end else begin
      range_step <= 1'b0;
      if (state == ST_TRACK) begin
        if (change) begin
          range_idx  <= next_idx;
          range_step <= 1'b1;
          settle_cnt <= cross_group ? CW'(LONG_SETTLE - 1) : CW'(SHORT_SETTLE - 1);
          state      <= ST_SETTLE;
        end
      end else begin
        if (settle_cnt == '0) state <= ST_TRACK;
        else settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

  assign bus.range_idx  = range_idx;
  assign bus.range_step = range_step;
  assign bus.settling   = (state == ST_SETTLE);
  assign bus.sat_flag   = (range_idx == RANGE_MAX) && full && hi_all;

endmodule
